risc_toy_pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage RISC_TOY core (IF, ID, EX, MEM, WB). It keeps a destination-register scoreboard for the EX, MEM and WB stages. From that scoreboard it produces operand-forwarding selects, load-use stalls, branch flushes and the fetch-enable (IREQ) gating. A small boot/halt state machine sequences core start-up and an orderly drain-to-halt.

---
 rtl/risc_toy_pipe_ctrl_if.sv | 39 +++
 rtl/risc_toy_pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_risc_toy_pipe_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_toy_pipe_ctrl_if.sv
// ID-stage request and pipeline-control response bundle for risc_toy_pipe_ctrl.
// master = core/ID side driving the requests, slave = the control unit.
interface risc_toy_pipe_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs0;
    logic [4:0] id_rs1;
    logic       id_rs0_en;
    logic       id_rs1_en;
    logic [4:0] id_rd;
    logic       id_rd_en;
    logic       id_is_load;
    logic       ex_br_taken;
    logic       halt_req;

    logic       ireq;
    logic       pc_hold;
    logic       stall_id;
    logic       bubble_ex;
    logic       flush_if;
    logic       flush_id;
    logic [1:0] fwd_sel0;
    logic [1:0] fwd_sel1;
    logic       halted;
    logic       busy;

    modport master (
        output id_valid, id_rs0, id_rs1, id_rs0_en, id_rs1_en,
               id_rd, id_rd_en, id_is_load, ex_br_taken, halt_req,
        input  ireq, pc_hold, stall_id, bubble_ex, flush_if, flush_id,
               fwd_sel0, fwd_sel1, halted, busy
    );

    modport slave (
        input  id_valid, id_rs0, id_rs1, id_rs0_en, id_rs1_en,
               id_rd, id_rd_en, id_is_load, ex_br_taken, halt_req,
        output ireq, pc_hold, stall_id, bubble_ex, flush_if, flush_id,
               fwd_sel0, fwd_sel1, halted, busy
    );
endinterface

// File: rtl/risc_toy_pipe_ctrl.sv
// RISC_TOY 5-stage pipeline control: EX/MEM/WB destination scoreboard, forwarding,
// load-use stall, branch flush and boot/drain/halt sequencing. PCTRL_PERF_EN adds stall/flush counters.
module risc_toy_pipe_ctrl #(
    parameter int BOOT_CYC = 4
) (
    input  logic CLK,
    input  logic RSTN,
    risc_toy_pipe_ctrl_if.slave bus
`ifdef PCTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    state_t    state, state_nxt;
    logic [7:0] boot_cnt, boot_cnt_nxt;
    sb_entry_t sb_ex, sb_mem, sb_wb;

    logic       in_run, in_drain;
    logic       flush, stall, bubble;
    logic [2:0] lk0, lk1;
    logic       unused_wb_load;

    // Youngest match wins; a load only forwards once it reaches WB, earlier it forces a stall.
    function automatic logic [2:0] fwd_lookup(input logic en, input logic [4:0] rs);
        logic [2:0] r;
        r = 3'b000;
        if (en && sb_ex.valid && sb_ex.rd == rs)
            r = {sb_ex.is_load, 2'd1};
        else if (en && sb_mem.valid && sb_mem.rd == rs)
            r = {sb_mem.is_load, 2'd2};
        else if (en && sb_wb.valid && sb_wb.rd == rs)
            r = {1'b0, 2'd3};
        return r;
    endfunction

    assign unused_wb_load = sb_wb.is_load;

    always_comb begin
        lk0      = fwd_lookup(bus.id_rs0_en, bus.id_rs0);
        lk1      = fwd_lookup(bus.id_rs1_en, bus.id_rs1);
        in_run   = (state == ST_RUN);
        in_drain = (state == ST_DRAIN);
        flush    = in_run & bus.ex_br_taken;
        stall    = in_run & bus.id_valid & (lk0[2] | lk1[2]) & ~bus.ex_br_taken;
        bubble   = stall | flush | in_drain;
    end

    assign bus.fwd_sel0  = lk0[1:0];
    assign bus.fwd_sel1  = lk1[1:0];
    assign bus.ireq      = in_run & ~stall & ~bus.halt_req;
    assign bus.pc_hold   = ~(in_run & ~stall & ~bus.halt_req);
    assign bus.stall_id  = stall;
    assign bus.bubble_ex = bubble;
    assign bus.flush_if  = flush | in_drain;
    assign bus.flush_id  = flush;
    assign bus.halted    = (state == ST_HALTED);
    assign bus.busy      = sb_ex.valid | sb_mem.valid | sb_wb.valid;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= ST_BOOT;
            boot_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            boot_cnt <= boot_cnt_nxt;
        end
    end

    // DRAIN leaves as soon as the scoreboard will be empty after this edge (WB retires now).
    always_comb begin
        state_nxt    = state;
        boot_cnt_nxt = boot_cnt;
        case (state)
            ST_BOOT: begin
                if (boot_cnt == 8'(BOOT_CYC - 1))
                    state_nxt = ST_RUN;
                else
                    boot_cnt_nxt = boot_cnt + 8'd1;
            end
            ST_RUN: begin
                if (bus.halt_req)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!sb_ex.valid && !sb_mem.valid)
                    state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                if (!bus.halt_req)
                    state_nxt = ST_RUN;
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            if (in_run && !bubble)
                sb_ex <= {bus.id_valid & bus.id_rd_en, bus.id_rd, bus.id_is_load};
            else
                sb_ex <= '0;
        end
    end

`ifdef PCTRL_PERF_EN
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_risc_toy_pipe_ctrl.sv
// Self-checking bench for risc_toy_pipe_ctrl: directed scenarios plus random traffic
// against an instruction-history reference model. Counters checked when PCTRL_PERF_EN is defined.
module tb_risc_toy_pipe_ctrl;

    localparam int BOOT_CYC = 4;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    risc_toy_pipe_ctrl_if bus();

`ifdef PCTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    risc_toy_pipe_ctrl #(.BOOT_CYC(BOOT_CYC)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus.slave)
`ifdef PCTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: what was issued 1, 2 and 3 cycles ago (age 0 = EX) plus a coarse mode.
    int          m_mode;
    int          m_boot;
    logic        h_v  [3];
    logic [4:0]  h_rd [3];
    logic        h_ld [3];
    logic [31:0] m_stall, m_flush;

    function automatic logic [2:0] m_lookup(input logic en, input logic [4:0] rs);
        logic [2:0] r;
        bit found;
        r = 3'b000;
        found = 0;
        for (int k = 0; k < 3; k++) begin
            if (!found && en && h_v[k] && h_rd[k] == rs) begin
                found = 1;
                r = {(k < 2) && h_ld[k], 2'(k + 1)};
            end
        end
        return r;
    endfunction

    function automatic logic m_stall_now();
        logic [2:0] a, b;
        a = m_lookup(bus.id_rs0_en, bus.id_rs0);
        b = m_lookup(bus.id_rs1_en, bus.id_rs1);
        return (m_mode == 1) && bus.id_valid && (a[2] || b[2]) && !bus.ex_br_taken;
    endfunction

    function automatic logic m_flush_now();
        return (m_mode == 1) && bus.ex_br_taken;
    endfunction

    function automatic logic [11:0] model_out();
        logic [2:0] a, b;
        logic st, fl, dr, fetch;
        a     = m_lookup(bus.id_rs0_en, bus.id_rs0);
        b     = m_lookup(bus.id_rs1_en, bus.id_rs1);
        st    = m_stall_now();
        fl    = m_flush_now();
        dr    = (m_mode == 2);
        fetch = (m_mode == 1) && !st && !bus.halt_req;
        return {fetch, !fetch, st, st | fl | dr, fl | dr, fl, m_mode == 3,
                h_v[0] | h_v[1] | h_v[2], a[1:0], b[1:0]};
    endfunction

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_mode  <= 0;
            m_boot  <= 0;
            m_stall <= 32'd0;
            m_flush <= 32'd0;
            for (int k = 0; k < 3; k++) begin
                h_v[k]  <= 1'b0;
                h_rd[k] <= 5'd0;
                h_ld[k] <= 1'b0;
            end
        end else begin
            if (m_stall_now()) m_stall <= m_stall + 32'd1;
            if (m_flush_now()) m_flush <= m_flush + 32'd1;
            h_v[0]  <= (m_mode == 1) && !m_stall_now() && !m_flush_now() && bus.id_valid && bus.id_rd_en;
            h_rd[0] <= bus.id_rd;
            h_ld[0] <= bus.id_is_load;
            for (int k = 1; k < 3; k++) begin
                h_v[k]  <= h_v[k-1];
                h_rd[k] <= h_rd[k-1];
                h_ld[k] <= h_ld[k-1];
            end
            case (m_mode)
                0: if (m_boot == BOOT_CYC - 1) m_mode <= 1; else m_boot <= m_boot + 1;
                1: if (bus.halt_req) m_mode <= 2;
                2: if (!h_v[0] && !h_v[1]) m_mode <= 3;
                default: if (!bus.halt_req) m_mode <= 1;
            endcase
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs0, input logic e0,
                          input logic [4:0] rs1, input logic e1,
                          input logic [4:0] rd, input logic rde, input logic ld);
        bus.id_valid   = v;
        bus.id_rs0     = rs0;
        bus.id_rs0_en  = e0;
        bus.id_rs1     = rs1;
        bus.id_rs1_en  = e1;
        bus.id_rd      = rd;
        bus.id_rd_en   = rde;
        bus.id_is_load = ld;
    endtask

    function automatic logic [11:0] dut_vec();
        return {bus.ireq, bus.pc_hold, bus.stall_id, bus.bubble_ex, bus.flush_if, bus.flush_id,
                bus.halted, bus.busy, bus.fwd_sel0, bus.fwd_sel1};
    endfunction

    task automatic test_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.ex_br_taken = 0;
        bus.halt_req    = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_vec++;
        if (dut_vec() !== 12'h400) begin
            n_err++;
            $display("[TB] FAIL reset_idle: got %h expected %h", dut_vec(), 12'h400);
        end
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1);
        bus.ex_br_taken = 1;
        bus.halt_req    = 1;
        #2;
        n_vec++;
        if (dut_vec() !== 12'h400) begin
            n_err++;
            $display("[TB] FAIL reset_busy_inputs: got %h expected %h", dut_vec(), 12'h400);
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.ex_br_taken = 0;
        bus.halt_req    = 0;
    endtask

    task automatic test_boot();
        @(posedge CLK);
        #1 RSTN = 1'b1;
        for (int c = 0; c <= BOOT_CYC; c++) begin
            @(negedge CLK);
            n_vec++;
            if (bus.ireq !== (c == BOOT_CYC) || bus.pc_hold !== (c != BOOT_CYC)) begin
                n_err++;
                $display("[TB] FAIL boot_cycle%0d: got ireq=%b pc_hold=%b expected ireq=%b pc_hold=%b",
                         c, bus.ireq, bus.pc_hold, c == BOOT_CYC, c != BOOT_CYC);
            end
            step();
        end
    endtask

    task automatic test_forward();
        set_id(1, 0, 0, 0, 0, 5'd3, 1, 0);
        step();
        set_id(1, 5'd3, 1, 5'd3, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            n_vec++;
            if (bus.fwd_sel0 !== 2'(i % 4) || bus.fwd_sel1 !== 2'(i % 4) || bus.stall_id !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL forward_age%0d: got sel0=%0d sel1=%0d stall=%b expected sel=%0d stall=0",
                         i, bus.fwd_sel0, bus.fwd_sel1, bus.stall_id, i % 4);
            end
            step();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        set_id(1, 0, 0, 0, 0, 5'd5, 1, 1);
        step();
        set_id(1, 5'd5, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_vec++;
            if (bus.stall_id !== (i < 2) || bus.bubble_ex !== (i < 2) || bus.pc_hold !== (i < 2)
                || bus.fwd_sel0 !== 2'(i + 1)) begin
                n_err++;
                $display("[TB] FAIL load_use_cycle%0d: got stall=%b bubble=%b hold=%b sel0=%0d expected %b %b %b %0d",
                         i, bus.stall_id, bus.bubble_ex, bus.pc_hold, bus.fwd_sel0, i < 2, i < 2, i < 2, i + 1);
            end
            step();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PCTRL_PERF_EN
        n_vec++;
        if (stall_cnt !== 32'd2) begin
            n_err++;
            $display("[TB] FAIL load_use_stall_cnt: got %0d expected 2", stall_cnt);
        end
`endif
        repeat (2) step();
    endtask

    task automatic test_flush_stall();
        set_id(1, 0, 0, 0, 0, 5'd7, 1, 1);
        step();
        set_id(1, 0, 0, 5'd7, 1, 0, 0, 0);
        bus.ex_br_taken = 1;
        @(negedge CLK);
        n_vec++;
        if ({bus.flush_if, bus.flush_id, bus.bubble_ex, bus.stall_id, bus.pc_hold} !== 5'b11100) begin
            n_err++;
            $display("[TB] FAIL flush_over_stall: got fi/fd/bx/st/ph=%b expected 11100",
                     {bus.flush_if, bus.flush_id, bus.bubble_ex, bus.stall_id, bus.pc_hold});
        end
        step();
        bus.ex_br_taken = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PCTRL_PERF_EN
        n_vec++;
        if (stall_cnt !== 32'd2 || flush_cnt !== 32'd1) begin
            n_err++;
            $display("[TB] FAIL flush_counters: got stall=%0d flush=%0d expected 2 1", stall_cnt, flush_cnt);
        end
`endif
        repeat (2) step();
    endtask

    task automatic test_halt();
        int  drain_cycles;
        bit  seen;
        for (int r = 1; r <= 3; r++) begin
            set_id(1, 0, 0, 0, 0, 5'(r), 1, 0);
            step();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.halt_req = 1;
        @(negedge CLK);
        n_vec++;
        if (bus.ireq !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL halt_ireq_drop: got ireq=%b busy=%b expected 0 1", bus.ireq, bus.busy);
        end
        step();
        drain_cycles = 0;
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge CLK);
            if (bus.halted === 1'b1) seen = 1;
            else begin
                drain_cycles++;
                step();
            end
        end
        n_vec++;
        if (!seen || drain_cycles > 3 || bus.busy !== 1'b0 || bus.ireq !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL halt_latency: got halted=%b drain=%0d busy=%b ireq=%b expected 1 <=3 0 0",
                     seen, drain_cycles, bus.busy, bus.ireq);
        end
        step();
        bus.halt_req = 0;
        @(negedge CLK);
        n_vec++;
        if (bus.halted !== 1'b1 || bus.ireq !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL halt_release_same: got halted=%b ireq=%b expected 1 0", bus.halted, bus.ireq);
        end
        step();
        @(negedge CLK);
        n_vec++;
        if (bus.halted !== 1'b0 || bus.ireq !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL halt_release_next: got halted=%b ireq=%b expected 0 1", bus.halted, bus.ireq);
        end
        step();
    endtask

    task automatic test_reset_in_drain();
        set_id(1, 0, 0, 0, 0, 5'd9, 1, 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.halt_req = 1;
        step();
        @(negedge CLK);
        n_vec++;
        if (bus.flush_if !== 1'b1 || bus.ireq !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL drain_entry: got flush_if=%b ireq=%b busy=%b expected 1 0 1",
                     bus.flush_if, bus.ireq, bus.busy);
        end
        #2 RSTN = 1'b0;
        #1;
        n_vec++;
        if (dut_vec() !== 12'h400) begin
            n_err++;
            $display("[TB] FAIL reset_in_drain: got %h expected %h", dut_vec(), 12'h400);
        end
        bus.halt_req = 0;
        test_boot();
    endtask

    task automatic test_random();
        logic [11:0] exp_v;
        bus.halt_req = 0;
        for (int n = 0; n < 2000; n++) begin
            set_id($urandom_range(3) != 0, 5'($urandom_range(7)), 1'($urandom_range(1)),
                   5'($urandom_range(7)), 1'($urandom_range(1)),
                   5'($urandom_range(7)), 1'($urandom_range(1)), $urandom_range(2) == 0);
            bus.ex_br_taken = ($urandom_range(7) == 0);
            if ($urandom_range(39) == 0) bus.halt_req = ~bus.halt_req;
            @(negedge CLK);
            exp_v = model_out();
            n_vec++;
            if (dut_vec() !== exp_v) begin
                n_err++;
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", n, dut_vec(), exp_v);
            end
`ifdef PCTRL_PERF_EN
            n_vec++;
            if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
                n_err++;
                $display("[TB] FAIL random_counters%0d: got %0d/%0d expected %0d/%0d",
                         n, stall_cnt, flush_cnt, m_stall, m_flush);
            end
`endif
            step();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.ex_br_taken = 0;
        bus.halt_req    = 0;
    endtask

    initial begin
        test_reset();
        test_boot();
        test_forward();
        test_load_use();
        test_flush_stall();
        test_halt();
        test_reset_in_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
